core_wb_arb: RTL and testbench
==============================

CORE_WB_ARB -- requirements
Module: core_wb_arb

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is synchronous and the reset is synchronous, active-high.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 alu_valid  in  1  ALU result present this cycle; no backpressure.
REQ-005 alu_addr  in  reg_addr_t (4)  ALU destination register.
REQ-006 alu_data  in  data_t (32)  ALU result.
REQ-007 lsu_valid  in  1  load result offered.
REQ-008 lsu_ready  out  1  FIFO can accept a load result; transfer when lsu_valid && lsu_ready.
REQ-009 lsu_addr  in  reg_addr_t (4)  load destination register.
REQ-010 lsu_data  in  data_t (32)  load data.
REQ-011 wb, wb_addr, wb_data  out  1/4/32  registered GPR write port.
REQ-012 rega_addr, regb_addr  in  reg_addr_t (4)  operand addresses from decode.
REQ-013 rega_pend, regb_pend  out  1 each  operand has a queued load write outstanding.
REQ-014 alu_hold  out  1  request upstream freeze; ALU must not issue while high.
REQ-015 Parameter FIFO_DEPTH, default 2: load-result FIFO entries, power of two, 2..8.
REQ-016 Parameter STARVE_LIM, default 4: cycles a FIFO head may wait before alu_hold is raised.

Function
REQ-017 Arbitration per cycle: the ALU result SHALL win if alu_valid is high; otherwise the FIFO head is written; otherwise an idle cycle.
REQ-018 The winning result SHALL appear on wb/wb_addr/wb_data on the next cycle, giving 1-cycle latency; wb is high for exactly one cycle per write.
REQ-019 A result with destination 4'hF SHALL be consumed but SHALL NOT assert wb, because register 15 is not implemented.
REQ-020 An accepted load result SHALL be enqueued in the cycle of the handshake; it SHALL NOT be written in that same cycle, so the minimum load-to-wb latency is 2 cycles.
REQ-021 lsu_ready = !full, computed from registered state only; there SHALL be no combinational path from lsu_valid.
REQ-022 Simultaneous enqueue and dequeue when full SHALL NOT be accepted, because ready is already low.
REQ-023 Simultaneous enqueue and dequeue when non-full SHALL leave the count unchanged.
REQ-024 Pointer wrap-around SHALL be modulo FIFO_DEPTH.
REQ-025 WAW squash: when an ALU write to address X is accepted, every valid FIFO entry with address X SHALL be invalidated in that cycle. An invalid head is popped without asserting wb, and the pop consumes an arbitration slot.
REQ-026 An entry enqueued in the same cycle as a matching ALU write SHALL NOT be squashed, because the load is younger.
REQ-027 rega_pend/regb_pend SHALL be combinational: high when any valid FIFO entry matches, or when an in-flight enqueue this cycle matches. Address 4'hF SHALL never report pending.
REQ-028 Starvation counter SHALL track head wait:
- increments each cycle the FIFO is non-empty and the ALU wins;
- clears on any FIFO pop;
- saturates at STARVE_LIM.
REQ-029 alu_hold SHALL be registered, high while counter == STARVE_LIM, and SHALL drop the cycle after the next pop.
REQ-030 Assertion: alu_valid && alu_hold SHALL flag a protocol error in simulation.

Reset
REQ-031 During rst, the block SHALL force:
- wb=0, wb_addr=0, wb_data=0;
- FIFO empty and all entries invalid;
- starvation counter=0, alu_hold=0.
REQ-032 lsu_ready SHALL be 0 during rst and 1 on the first cycle after rst deasserts.
REQ-033 Reset mid-operation SHALL discard all queued loads and SHALL NOT produce a write on the cycle after rst.

Verification
REQ-034 ALU only: alu_valid, addr 3, data 0x11 at cycle 0 -> wb=1, wb_addr=3, wb_data=0x11 at cycle 1; no further wb.
REQ-035 Conflict: ALU (addr 1, 0xA) and load (addr 2, 0xB) both at cycle 0 -> cycle 1 writes r1=0xA; cycle 2 writes r2=0xB; regb_pend for r2 high in cycles 0-1.
REQ-036 Full FIFO: ALU valid every cycle, two loads accepted -> lsu_ready=0 in cycle 2; after 4 ALU wins alu_hold=1; with ALU idle, both loads drain in order and alu_hold falls after the first pop.
REQ-037 WAW squash: load addr 5 queued, then ALU addr 5 data 0x77 -> only r5=0x77 written; queued entry is popped without wb; rega_pend(5) falls after the squash.
REQ-038 Register 15: ALU or load to addr 4'hF -> no wb; FIFO count returns to 0.
REQ-039 Reset mid-operation: rst with 2 queued loads -> wb=0 on the following cycle, lsu_ready=1, rega_pend=regb_pend=0.

Source files
------------

// File: rtl/core_wb_arb_if.sv
// Write-back arbiter bus: ALU result, LSU load handshake, GPR write port,
// operand pending lookup and upstream hold.
interface core_wb_arb_if;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_addr;
    logic [31:0] lsu_data;

    logic        wb;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    logic [3:0]  rega_addr;
    logic [3:0]  regb_addr;
    logic        rega_pend;
    logic        regb_pend;

    logic        alu_hold;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output lsu_ready,
        output wb, wb_addr, wb_data,
        input  rega_addr, regb_addr,
        output rega_pend, regb_pend,
        output alu_hold
    );

    // Core side (ALU, LSU, decode, register file).
    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  lsu_ready,
        input  wb, wb_addr, wb_data,
        output rega_addr, regb_addr,
        input  rega_pend, regb_pend,
        input  alu_hold
    );
endinterface

// File: rtl/core_wb_arb.sv
// Single-port GPR write-back arbiter. ALU results always win; load results
// queue in a small FIFO and drain on idle ALU cycles. A younger ALU write
// squashes queued loads to the same register, and a starvation counter
// raises alu_hold so the FIFO head is guaranteed to drain eventually.
module core_wb_arb #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic          clk,
    input logic          rst,
    core_wb_arb_if.slave bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StvW = $clog2(STARVE_LIM + 1);

    localparam logic [CntW-1:0] CntFull   = CntW'(FIFO_DEPTH);
    localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIM);
    // Destination that is consumed without a register write.
    localparam logic [3:0]      RegNone   = 4'hF;

    logic [3:0]            fifo_addr_q [FIFO_DEPTH];
    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [StvW-1:0]       starve_q, starve_d;
    logic                  hold_q;
    logic                  wb_q, wb_d;
    logic [3:0]            wb_addr_q, wb_addr_d;
    logic [31:0]           wb_data_q, wb_data_d;

    logic lsu_ready;
    logic enq;
    logic pop;
    logic empty;
    logic head_vld;
    logic rega_hit, regb_hit;

    // Handshake and arbitration decisions from registered state.
    always_comb begin
        empty     = (cnt_q == '0);
        // rst gating keeps ready low during reset; no path from lsu_valid.
        lsu_ready = !rst && (cnt_q != CntFull);
        enq       = bus.lsu_valid && lsu_ready;
        pop       = !bus.alu_valid && !empty;
        head_vld  = fifo_vld_q[rd_ptr_q];
    end

    // Entry valid bits: squash on matching ALU write, clear on pop, set on enqueue.
    always_comb begin
        fifo_vld_d = fifo_vld_q;
        if (bus.alu_valid) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                if (fifo_vld_q[i] && (fifo_addr_q[i] == bus.alu_addr)) begin
                    fifo_vld_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
        end
        // Applied last: a same-cycle enqueue is younger than the ALU write.
        if (enq) begin
            fifo_vld_d[wr_ptr_q] = (bus.lsu_addr != RegNone);
        end
    end

    // Occupancy, winner selection and starvation tracking.
    always_comb begin
        cnt_d     = cnt_q + CntW'(enq) - CntW'(pop);
        wb_d      = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (bus.alu_valid) begin
            wb_d      = (bus.alu_addr != RegNone);
            wb_addr_d = bus.alu_addr;
            wb_data_d = bus.alu_data;
        end else if (pop) begin
            // Squashed or r15 heads still take the slot but do not write.
            wb_d      = head_vld;
            wb_addr_d = fifo_addr_q[rd_ptr_q];
            wb_data_d = fifo_data_q[rd_ptr_q];
        end

        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (bus.alu_valid && !empty && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Pending lookup over queued entries plus this cycle's enqueue.
    always_comb begin
        rega_hit = enq && (bus.lsu_addr == bus.rega_addr);
        regb_hit = enq && (bus.lsu_addr == bus.regb_addr);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (fifo_vld_q[i] && (fifo_addr_q[i] == bus.rega_addr)) begin
                rega_hit = 1'b1;
            end
            if (fifo_vld_q[i] && (fifo_addr_q[i] == bus.regb_addr)) begin
                regb_hit = 1'b1;
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            hold_q     <= 1'b0;
            wb_q       <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            hold_q     <= (starve_d == StarveMax);
            wb_q       <= wb_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            // Power-of-two depth makes the natural wrap modulo FIFO_DEPTH.
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q] <= bus.lsu_addr;
            fifo_data_q[wr_ptr_q] <= bus.lsu_data;
        end
    end

    assign bus.lsu_ready = lsu_ready;
    assign bus.wb        = wb_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.alu_hold  = hold_q;
    assign bus.rega_pend = rega_hit && (bus.rega_addr != RegNone);
    assign bus.regb_pend = regb_hit && (bus.regb_addr != RegNone);

    // Upstream must not issue an ALU result while hold is raised.
    alu_hold_protocol: assert property (@(posedge clk) disable iff (rst)
        !(bus.alu_valid && hold_q));

endmodule

// File: tb/tb_core_wb_arb.sv
// Directed bench for core_wb_arb: expected writes go into a scoreboard queue
// tagged with their cycle; a monitor pops and compares on every wb pulse.
module tb_core_wb_arb;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    wb_t  exp_q[$];
    wb_t  mon_e;
    int   c0;

    core_wb_arb_if bus();

    core_wb_arb #(
        .FIFO_DEPTH(2),
        .STARVE_LIM(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_wb(input int c, input logic [3:0] a, input logic [31:0] d);
        wb_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [3:0] la, input logic [31:0] ld);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_addr  = la;
        bus.lsu_data  = ld;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every wb pulse must match the oldest expected write, cycle included.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got r%0d=%0h at cycle %0d, expected no write",
                             bus.wb_addr, bus.wb_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_write", {16'(cyc), 12'h0, bus.wb_addr, bus.wb_data},
                          {16'(mon_e.cyc), 12'h0, mon_e.addr, mon_e.data});
                end
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.rega_addr = 4'h0;
        bus.regb_addr = 4'h0;
        idle();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        mid();
        check("rst_lsu_ready", bus.lsu_ready, 1'b0);
        check("rst_wb", bus.wb, 1'b0);
        check("rst_wb_addr", bus.wb_addr, 4'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_alu_hold", bus.alu_hold, 1'b0);
        next();
        rst = 1'b0;
        mid();
        check("post_rst_lsu_ready", bus.lsu_ready, 1'b1);
        next();

        // ALU only: one write one cycle later, nothing after.
        c0 = cyc;
        drive(1'b1, 4'h3, 32'h11, 1'b0, 4'h0, 32'h0);
        expect_wb(c0 + 1, 4'h3, 32'h11);
        next();
        idle();
        repeat (3) next();

        // ALU and load together: ALU first, load the cycle after.
        c0 = cyc;
        bus.regb_addr = 4'h2;
        drive(1'b1, 4'h1, 32'hA, 1'b1, 4'h2, 32'hB);
        expect_wb(c0 + 1, 4'h1, 32'hA);
        expect_wb(c0 + 2, 4'h2, 32'hB);
        mid();
        check("conflict_regb_pend_c0", bus.regb_pend, 1'b1);
        check("conflict_lsu_ready_c0", bus.lsu_ready, 1'b1);
        next();
        idle();
        mid();
        check("conflict_regb_pend_c1", bus.regb_pend, 1'b1);
        next();
        mid();
        check("conflict_regb_pend_c2", bus.regb_pend, 1'b0);
        next();
        next();

        // Full FIFO and starvation hold.
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] aa;
            aa = (i == 4) ? 4'h9 : 4'(i + 1);
            if (i == 0)      drive(1'b1, aa, 32'h100 + 32'(i), 1'b1, 4'h7, 32'h70);
            else if (i == 1) drive(1'b1, aa, 32'h100 + 32'(i), 1'b1, 4'h8, 32'h80);
            else if (i == 2) drive(1'b1, aa, 32'h100 + 32'(i), 1'b1, 4'hA, 32'hDEAD);
            else             drive(1'b1, aa, 32'h100 + 32'(i), 1'b0, 4'h0, 32'h0);
            expect_wb(c0 + i + 1, aa, 32'h100 + 32'(i));
            mid();
            if (i < 2)  check("full_lsu_ready_open", bus.lsu_ready, 1'b1);
            if (i == 2) check("full_lsu_ready_c2", bus.lsu_ready, 1'b0);
            if (i == 4) check("full_alu_hold_c4", bus.alu_hold, 1'b0);
            next();
        end
        idle();
        expect_wb(c0 + 6, 4'h7, 32'h70);
        expect_wb(c0 + 7, 4'h8, 32'h80);
        mid();
        check("full_alu_hold_c5", bus.alu_hold, 1'b1);
        next();
        mid();
        check("full_alu_hold_c6", bus.alu_hold, 1'b0);
        check("full_lsu_ready_c6", bus.lsu_ready, 1'b1);
        next();
        next();
        next();

        // WAW squash of a queued load.
        c0 = cyc;
        bus.rega_addr = 4'h5;
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h5, 32'h55);
        mid();
        check("waw_rega_pend_c0", bus.rega_pend, 1'b1);
        next();
        drive(1'b1, 4'h5, 32'h77, 1'b0, 4'h0, 32'h0);
        expect_wb(c0 + 2, 4'h5, 32'h77);
        mid();
        check("waw_rega_pend_c1", bus.rega_pend, 1'b1);
        next();
        idle();
        mid();
        check("waw_rega_pend_c2", bus.rega_pend, 1'b0);
        next();
        next();

        // Same-cycle enqueue is younger than the ALU write: not squashed.
        c0 = cyc;
        drive(1'b1, 4'h6, 32'h60, 1'b1, 4'h6, 32'h66);
        expect_wb(c0 + 1, 4'h6, 32'h60);
        expect_wb(c0 + 2, 4'h6, 32'h66);
        next();
        idle();
        repeat (3) next();

        // Register 15: consumed, never written, never pending.
        c0 = cyc;
        bus.regb_addr = 4'hF;
        drive(1'b1, 4'hF, 32'h99, 1'b1, 4'hF, 32'h98);
        mid();
        check("r15_regb_pend", bus.regb_pend, 1'b0);
        next();
        idle();
        next();
        drive(1'b1, 4'hD, 32'hD0, 1'b1, 4'hB, 32'hB1);
        expect_wb(c0 + 3, 4'hD, 32'hD0);
        mid();
        check("r15_lsu_ready_c2", bus.lsu_ready, 1'b1);
        next();
        drive(1'b1, 4'hE, 32'hE0, 1'b1, 4'hC, 32'hC1);
        expect_wb(c0 + 4, 4'hE, 32'hE0);
        mid();
        check("r15_lsu_ready_c3", bus.lsu_ready, 1'b1);
        next();
        idle();
        expect_wb(c0 + 5, 4'hB, 32'hB1);
        expect_wb(c0 + 6, 4'hC, 32'hC1);
        mid();
        check("r15_lsu_ready_c4", bus.lsu_ready, 1'b0);
        repeat (4) next();

        // Reset with two loads queued.
        c0 = cyc;
        bus.rega_addr = 4'h2;
        bus.regb_addr = 4'h3;
        drive(1'b1, 4'h4, 32'h40, 1'b1, 4'h2, 32'h22);
        expect_wb(c0 + 1, 4'h4, 32'h40);
        next();
        drive(1'b1, 4'h6, 32'h60, 1'b1, 4'h3, 32'h33);
        expect_wb(c0 + 2, 4'h6, 32'h60);
        next();
        idle();
        rst = 1'b1;
        mid();
        check("midrst_lsu_ready_in_rst", bus.lsu_ready, 1'b0);
        next();
        rst = 1'b0;
        mid();
        check("midrst_wb", bus.wb, 1'b0);
        check("midrst_lsu_ready", bus.lsu_ready, 1'b1);
        check("midrst_rega_pend", bus.rega_pend, 1'b0);
        check("midrst_regb_pend", bus.regb_pend, 1'b0);
        check("midrst_alu_hold", bus.alu_hold, 1'b0);
        repeat (4) next();

        mid();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
